// File: rtl/mtx_load_arbiter.sv
// mtx_load_arbiter: round-robin owner of the serial matrix-load bus, snapshots and serializes 8 cells
module mtx_load_arbiter #(
    parameter int CELL_W = 19,
    parameter int GAP    = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            req,
    input  logic [8*CELL_W-1:0]   req0_matrix,
    input  logic [8*CELL_W-1:0]   req1_matrix,
    input  logic                  abort,
    output logic [CELL_W-1:0]     matrix_cell,
    output logic                  imag,
    output logic                  col,
    output logic                  row,
    output logic                  ready,
    output logic [1:0]            grant,
    output logic [1:0]            done,
    output logic                  busy
);
    typedef enum logic [1:0] {IDLE, SEND, WAIT, DONE} state_t;

    state_t              state, state_n;
    logic [2:0]          k, k_n;
    logic [3:0]          gap_cnt, gap_n;
    logic                rr, rr_n;
    logic [8*CELL_W-1:0] snap, snap_n, src;
    logic [CELL_W-1:0]   cell_n;
    logic [2:0]          idx, idx_n, sel;
    logic                ready_n, busy_n, load, win;
    logic [1:0]          grant_n, done_n;

    assign {row, col, imag} = idx;

    // next-state and output decode; load marks a cycle that presents cell sel on the bus
    always_comb begin
        state_n = state;
        k_n     = k;
        gap_n   = gap_cnt;
        rr_n    = rr;
        snap_n  = snap;
        cell_n  = matrix_cell;
        idx_n   = idx;
        ready_n = 1'b0;
        grant_n = grant;
        done_n  = 2'b00;
        busy_n  = busy;
        load    = 1'b0;
        sel     = k;
        src     = snap;
        win     = (req == 2'b11) ? rr : req[1];
        case (state)
            IDLE: if (req != 2'b00) begin
                rr_n    = (req == 2'b11) ? ~rr : rr;
                snap_n  = win ? req1_matrix : req0_matrix;
                src     = snap_n;
                grant_n = win ? 2'b10 : 2'b01;
                busy_n  = 1'b1;
                k_n     = 3'd0;
                sel     = 3'd0;
                load    = 1'b1;
                state_n = SEND;
            end
            SEND: if (abort) begin
                grant_n = 2'b00;
                busy_n  = 1'b0;
                state_n = IDLE;
            end else if (k == 3'd7) begin
                grant_n = 2'b00;
                done_n  = grant;
                state_n = DONE;
            end else if (GAP > 0) begin
                gap_n   = 4'(GAP - 1);
                k_n     = k + 3'd1;
                state_n = WAIT;
            end else begin
                k_n     = k + 3'd1;
                sel     = k_n;
                load    = 1'b1;
            end
            WAIT: if (abort) begin
                grant_n = 2'b00;
                busy_n  = 1'b0;
                state_n = IDLE;
            end else if (gap_cnt != 4'd0) begin
                gap_n   = gap_cnt - 4'd1;
            end else begin
                load    = 1'b1;
                state_n = SEND;
            end
            DONE: begin
                busy_n  = 1'b0;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
        if (load) begin
            ready_n = 1'b1;
            cell_n  = src[CELL_W*sel +: CELL_W];
            idx_n   = sel;
        end
    end

    // state and registered outputs, cleared asynchronously
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            k           <= 3'd0;
            gap_cnt     <= 4'd0;
            rr          <= 1'b0;
            snap        <= '0;
            matrix_cell <= '0;
            idx         <= 3'd0;
            ready       <= 1'b0;
            grant       <= 2'b00;
            done        <= 2'b00;
            busy        <= 1'b0;
        end else begin
            state       <= state_n;
            k           <= k_n;
            gap_cnt     <= gap_n;
            rr          <= rr_n;
            snap        <= snap_n;
            matrix_cell <= cell_n;
            idx         <= idx_n;
            ready       <= ready_n;
            grant       <= grant_n;
            done        <= done_n;
            busy        <= busy_n;
        end
    end
endmodule

// File: tb/tb_mtx_load_arbiter.sv
// tb_mtx_load_arbiter: directed checks of arbitration, serialization, gaps, abort and reset
module tb_mtx_load_arbiter;
    localparam int W = 19;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [1:0]     req0 = 2'b00, req3 = 2'b00;
    logic [8*W-1:0] m0a = '0, m0b = '0, m3a = '0, m3b = '0;
    logic           abort0 = 1'b0, abort3 = 1'b0;
    logic [W-1:0]   cell0, cell3;
    logic           imag0, col0, row0, ready0, busy0;
    logic           imag3, col3, row3, ready3, busy3;
    logic [1:0]     grant0, done0, grant3, done3;
    logic [W-1:0]   dec [8];
    int             errors = 0;
    int             checks = 0;

    always #5 clk = ~clk;

    mtx_load_arbiter #(.CELL_W(W), .GAP(0)) u0 (
        .clk(clk), .reset(reset), .req(req0), .req0_matrix(m0a), .req1_matrix(m0b),
        .abort(abort0), .matrix_cell(cell0), .imag(imag0), .col(col0), .row(row0),
        .ready(ready0), .grant(grant0), .done(done0), .busy(busy0));

    mtx_load_arbiter #(.CELL_W(W), .GAP(3)) u3 (
        .clk(clk), .reset(reset), .req(req3), .req0_matrix(m3a), .req1_matrix(m3b),
        .abort(abort3), .matrix_cell(cell3), .imag(imag3), .col(col3), .row(row3),
        .ready(ready3), .grant(grant3), .done(done3), .busy(busy3));

    // decoder model: stores each cell at its {row,col,imag} address when ready
    always @(posedge clk) if (ready0) dec[{row0, col0, imag0}] <= cell0;

    function automatic logic [8*W-1:0] alt(input int s);
        logic [8*W-1:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            int v;
            v = s * (i + 1);
            if (i % 2 == 1) v = -v;
            r[W*i +: W] = W'(v);
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // req already driven at a negedge; next posedge is the grant edge. Ends at the done negedge.
    task automatic xfer0(input logic [8*W-1:0] m, input logic [1:0] g, input bit mut);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk($sformatf("ready_c%0d", i), {31'd0, ready0}, 32'd1);
            chk($sformatf("idx_c%0d", i), {29'd0, row0, col0, imag0}, 32'(i));
            chk($sformatf("cell_c%0d", i), {13'd0, cell0}, {13'd0, m[W*i +: W]});
            chk($sformatf("grant_c%0d", i), {30'd0, grant0}, {30'd0, g});
            if (mut && i == 1) begin
                m0a = '1;
                req0[0] = 1'b0;
            end
        end
        @(negedge clk);
        chk("done_pulse", {30'd0, done0}, {30'd0, g});
        chk("ready_after", {31'd0, ready0}, 32'd0);
    endtask

    initial begin
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_ready", {31'd0, ready0}, 32'd0);
        chk("rst_grant", {30'd0, grant0}, 32'd0);
        chk("rst_busy", {31'd0, busy0}, 32'd0);
        chk("rst_cell", {13'd0, cell0}, 32'd0);
        reset = 1'b1;
        @(negedge clk);
        // single request, GAP=0: 1,-2,...,-8
        m0a = alt(1);
        req0 = 2'b01;
        xfer0(alt(1), 2'b01, 1'b0);
        chk("cell0_val", {13'd0, cell0}, {13'd0, 19'h7FFF8});
        req0 = 2'b00;
        @(negedge clk);
        chk("done_clear", {30'd0, done0}, 32'd0);
        chk("busy_clear", {31'd0, busy0}, 32'd0);
        chk("dec_111", {13'd0, dec[7]}, {13'd0, 19'h7FFF8});
        chk("dec_000", {13'd0, dec[0]}, 32'd1);
        // tie held continuously: 01, 10, 01
        m0b = alt(10);
        req0 = 2'b11;
        xfer0(alt(1), 2'b01, 1'b0);
        @(negedge clk);
        xfer0(alt(10), 2'b10, 1'b0);
        @(negedge clk);
        xfer0(alt(1), 2'b01, 1'b0);
        req0 = 2'b00;
        @(negedge clk);
        // snapshot isolation: matrix and req change mid-transfer
        m0a = alt(3);
        req0 = 2'b01;
        xfer0(alt(3), 2'b01, 1'b1);
        @(negedge clk);
        // abort after cell 3; pending req[1] wins next since rr points to 1
        m0a = alt(2);
        req0 = 2'b01;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("ab_cell%0d", i), {13'd0, cell0}, {13'd0, alt(2)[W*i +: W]});
            if (i == 0) req0 = 2'b11;
        end
        abort0 = 1'b1;
        @(negedge clk);
        abort0 = 1'b0;
        chk("ab_ready", {31'd0, ready0}, 32'd0);
        chk("ab_busy", {31'd0, busy0}, 32'd0);
        chk("ab_grant", {30'd0, grant0}, 32'd0);
        chk("ab_done", {30'd0, done0}, 32'd0);
        xfer0(alt(10), 2'b10, 1'b0);
        @(negedge clk);
        xfer0(alt(2), 2'b01, 1'b0);
        req0 = 2'b00;
        @(negedge clk);
        // reset during cell 5
        m0a = alt(1);
        req0 = 2'b01;
        repeat (6) @(negedge clk);
        chk("pre_rst_idx", {29'd0, row0, col0, imag0}, 32'd5);
        #2 reset = 1'b0;
        req0 = 2'b00;
        #1;
        chk("arst_ready", {31'd0, ready0}, 32'd0);
        chk("arst_grant", {30'd0, grant0}, 32'd0);
        chk("arst_busy", {31'd0, busy0}, 32'd0);
        chk("arst_cell", {13'd0, cell0}, 32'd0);
        chk("arst_idx", {29'd0, row0, col0, imag0}, 32'd0);
        @(negedge clk);
        chk("arst_done", {30'd0, done0}, 32'd0);
        reset = 1'b1;
        m0b = alt(4);
        req0 = 2'b10;
        xfer0(alt(4), 2'b10, 1'b0);
        req0 = 2'b00;
        @(negedge clk);
        // GAP=3: ready every 4 cycles, done 29 cycles after grant edge
        m3a = alt(2);
        req3 = 2'b01;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk($sformatf("g3_ready%0d", i), {31'd0, ready3}, 32'd1);
            chk($sformatf("g3_cell%0d", i), {13'd0, cell3}, {13'd0, alt(2)[W*i +: W]});
            chk($sformatf("g3_idx%0d", i), {29'd0, row3, col3, imag3}, 32'(i));
            if (i < 7) repeat (3) begin
                @(negedge clk);
                chk($sformatf("g3_gap%0d", i), {31'd0, ready3}, 32'd0);
                chk($sformatf("g3_nodone%0d", i), {30'd0, done3}, 32'd0);
            end
        end
        @(negedge clk);
        chk("g3_done", {30'd0, done3}, 32'd1);
        req3 = 2'b00;
        @(negedge clk);
        chk("g3_busy", {31'd0, busy3}, 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
